// File: rtl/regwb_sched.sv
// Write-back scheduler and load scoreboard for the register file's single write port.
// Optional: define REGWB_STALLCNT_EN to add the collide_cnt output.
module regwb_sched #(
   parameter int unsigned AWIDTH  = 4,
   parameter int unsigned DWIDTH  = 16,
   parameter int unsigned LQDEPTH = 2,
   parameter int unsigned MAXOUT  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [AWIDTH-1:0] ex_wsel,
   input  logic [DWIDTH-1:0] ex_wdata,
   input  logic              ld_issue,
   input  logic [AWIDTH-1:0] ld_issue_sel,
   output logic              ld_issue_ready,
   input  logic              ld_valid,
   input  logic [AWIDTH-1:0] ld_sel,
   input  logic [DWIDTH-1:0] ld_data,
   output logic              ld_ready,
   input  logic [AWIDTH-1:0] chk_asel,
   input  logic [AWIDTH-1:0] chk_bsel,
   input  logic [AWIDTH-1:0] chk_wsel,
   output logic              hazard,
   output logic              rf_wreg,
   output logic [AWIDTH-1:0] rf_wsel,
   output logic [DWIDTH-1:0] rf_wdata
`ifdef REGWB_STALLCNT_EN
   ,
   output logic [15:0]       collide_cnt
`endif
);

   localparam int unsigned NReg = 1 << AWIDTH;
   localparam int unsigned PtrW = (LQDEPTH > 1) ? $clog2(LQDEPTH) : 1;
   localparam int unsigned OccW = $clog2(LQDEPTH) + 1;
   localparam int unsigned CntW = $clog2(MAXOUT + 1);
   localparam int unsigned EntW = AWIDTH + DWIDTH;

   localparam logic [OccW-1:0] OccFull = OccW'(LQDEPTH);
   localparam logic [CntW-1:0] CntMax  = CntW'(MAXOUT);

   logic [EntW-1:0]   fifo_q [LQDEPTH];
   logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [OccW-1:0]   occ_q, occ_d;
   logic              fifo_empty, push, pop, ld_acc;

   logic [NReg-1:0]   pending_q, pending_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              sb_set, sb_clr;

   logic              wreg_q, wreg_d, isld_q, isld_d;
   logic [AWIDTH-1:0] wsel_q, wsel_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;

   assign fifo_empty = (occ_q == '0);
   assign ld_ready   = (occ_q != OccFull);
   assign ld_acc     = ld_valid & ld_ready;

   assign ld_issue_ready = (cnt_q < CntMax) & ~pending_q[ld_issue_sel];
   assign hazard = pending_q[chk_asel] | pending_q[chk_bsel] | pending_q[chk_wsel];

   assign rf_wreg  = wreg_q;
   assign rf_wsel  = wsel_q;
   assign rf_wdata = wdata_q;

   // Strict priority: ALU, then FIFO head, then bypass of the returning load.
   always_comb begin
      wreg_d  = 1'b0;
      isld_d  = 1'b0;
      wsel_d  = wsel_q;
      wdata_d = wdata_q;
      pop     = 1'b0;
      if (ex_valid) begin
         wreg_d  = 1'b1;
         wsel_d  = ex_wsel;
         wdata_d = ex_wdata;
      end else if (!fifo_empty) begin
         wreg_d  = 1'b1;
         isld_d  = 1'b1;
         pop     = 1'b1;
         {wsel_d, wdata_d} = fifo_q[rptr_q];
      end else if (ld_acc) begin
         wreg_d  = 1'b1;
         isld_d  = 1'b1;
         wsel_d  = ld_sel;
         wdata_d = ld_data;
      end
      push = ld_acc & (ex_valid | !fifo_empty);
   end

   always_comb begin
      wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + PtrW'(1) : rptr_q;
      occ_d  = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + OccW'(1);
      end else if (!push && pop) begin
         occ_d = occ_q - OccW'(1);
      end
   end

   // A commit only retires a bit that is actually pending, so stray returns leave the count alone.
   assign sb_clr = wreg_q & isld_q & pending_q[wsel_q];
   assign sb_set = ld_issue & ld_issue_ready;

   always_comb begin
      pending_d = pending_q;
      if (sb_clr) pending_d[wsel_q] = 1'b0;
      if (sb_set) pending_d[ld_issue_sel] = 1'b1;
      cnt_d = cnt_q;
      if (sb_set && !sb_clr) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!sb_set && sb_clr) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         occ_q     <= '0;
         pending_q <= '0;
         cnt_q     <= '0;
         wreg_q    <= 1'b0;
         isld_q    <= 1'b0;
         wsel_q    <= '0;
         wdata_q   <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         occ_q     <= occ_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         wreg_q    <= wreg_d;
         isld_q    <= isld_d;
         wsel_q    <= wsel_d;
         wdata_q   <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= {ld_sel, ld_data};
   end

`ifdef REGWB_STALLCNT_EN
   logic [15:0] collide_q, collide_d;

   always_comb begin
      collide_d = collide_q;
      if (ex_valid && !fifo_empty && collide_q != 16'hFFFF) collide_d = collide_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) collide_q <= '0;
      else        collide_q <= collide_d;
   end

   assign collide_cnt = collide_q;
`endif

   // Protocol checks: ALU must not target a pending register; returns must match a pending load.
   a_ex_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
      ex_valid |-> !pending_q[ex_wsel]);
   a_ld_is_pending: assert property (@(posedge clk) disable iff (!rst_n)
      (ld_valid && ld_ready) |-> pending_q[ld_sel]);

endmodule
